// File: rtl/led_pwm_blink_pkg.sv
// Shared constants for the LED PWM/blink controller: register map and reset values.
package led_pwm_blink_pkg;

  localparam logic [1:0] ADDR_DUTY   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [7:0] DUTY_RST   = 8'hFF;
  localparam logic [7:0] MASK_RST   = 8'h00;
  localparam logic [7:0] PERIOD_RST = 8'h00;

  // Full-scale duty: LED is on every cycle rather than 255 of 256.
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // PWM comparator with the full-scale override folded in.
  function automatic logic pwm_on_f(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/led_pwm_blink_if.sv
// Avalon-MM slave register port of the LED controller.
// Handshake: a write is taken on any rising clock edge where chipselect=1 and
// write_n=0 (no wait states, no back-pressure); readdata is a pure function of
// address and is valid in the same cycle regardless of chipselect.
interface led_pwm_blink_if;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_blink_prescaler.sv
// Blink timebase: prefix tick counter, step counter and the blink phase bit.
// A restart (PERIOD write) zeroes both counters and forces phase high, and it
// wins over a step or toggle that falls on the same edge.
module led_blink_prescaler #(
  parameter int TICK_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [7:0] period,
  output logic       blink_phase
);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        step_cnt_q, step_cnt_d;
  logic              phase_q, phase_d;
  logic              step;

  // Step fires on the edge where tick_cnt wraps back to zero.
  assign step = &tick_cnt_q;

  // Next-state: count ticks, count steps, toggle phase at the end of a half-period.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    if (step) begin
      if (step_cnt_q == period) begin
        step_cnt_d = 8'd0;
        phase_d    = ~phase_q;
      end else begin
        step_cnt_d = step_cnt_q + 8'd1;
      end
    end
    if (restart) begin
      tick_cnt_d = '0;
      step_cnt_d = 8'd0;
      phase_d    = 1'b1;
    end
  end

  // State registers with asynchronous reset to the start of a high phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      step_cnt_q <= 8'd0;
      phase_q    <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/led_pwm_blink.sv
// LED dimmer/blinker: Avalon-MM registers, 8-bit PWM and a registered LED output
// stage gated by a per-LED blink mask and the prescaler's blink phase.
module led_pwm_blink
  import led_pwm_blink_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  led_pwm_blink_if.slave        bus,
  input  logic [7:0]            led_in,
  output logic [7:0]            led_out
);

  logic [7:0] duty_q, duty_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] period_q, period_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0] led_out_q, led_out_d;
  logic       wr_en;
  logic       period_wr;
  logic       blink_phase;
  logic       pwm_on;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign period_wr = wr_en && (bus.address == ADDR_PERIOD);

  led_blink_prescaler #(
    .TICK_W (TICK_W)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .restart     (period_wr),
    .period      (period_q),
    .blink_phase (blink_phase)
  );

  // Register file write decode; STATUS is read-only so address 3 drops the write.
  always_comb begin
    duty_d   = duty_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DUTY:   duty_d   = bus.writedata;
        ADDR_MASK:   mask_d   = bus.writedata;
        ADDR_PERIOD: period_d = bus.writedata;
        default:     ;
      endcase
    end
  end

  // PWM counter advance and LED output stage from current registers and phase.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_on    = pwm_on_f(pwm_cnt_q, duty_q);
    led_out_d = led_in & {8{pwm_on}} & (~mask_q | {8{blink_phase}});
  end

  // Registers, PWM counter and output drive with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= DUTY_RST;
      mask_q    <= MASK_RST;
      period_q  <= PERIOD_RST;
      pwm_cnt_q <= 8'd0;
      led_out_q <= 8'h00;
    end else begin
      duty_q    <= duty_d;
      mask_q    <= mask_d;
      period_q  <= period_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
    end
  end

  // Zero-wait-state read mux, decoded from address only.
  always_comb begin
    bus.readdata = 8'h00;
    case (bus.address)
      ADDR_DUTY:   bus.readdata = duty_q;
      ADDR_MASK:   bus.readdata = mask_q;
      ADDR_PERIOD: bus.readdata = period_q;
      ADDR_STATUS: bus.readdata = {7'b0, blink_phase};
      default:     bus.readdata = 8'h00;
    endcase
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_blink.sv
// Directed bench for led_pwm_blink with a 4-bit blink prefix (16-cycle steps).
module tb_led_pwm_blink;

  logic       clk;
  logic       reset;
  logic [7:0] led_in;
  logic [7:0] led_out;
  int         checks;
  int         errors;

  led_pwm_blink_if bus_if ();

  led_pwm_blink #(
    .TICK_W (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .led_in  (led_in),
    .led_out (led_out)
  );

  // Clock and initial input levels
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Write edge is the next rising edge after the call.
  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
    led_in = 8'hA5;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_led_out: got %h expected 00", led_out);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led_out !== 8'hA5) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_passthrough: %0d cycles differed from A5", bad);
    end
    for (int a = 0; a < 4; a++) begin
      bus_if.address = 2'(a);
      #1;
      checks++;
      if (bus_if.readdata !== exp_rd[a]) begin
        errors++;
        $display("FAIL reset_read_addr%0d: got %h expected %h", a, bus_if.readdata, exp_rd[a]);
      end
    end
  endtask

  task automatic test_pwm();
    int n_on, n_off, n_other;
    logic [7:0] duties [3];
    int exp_on [3];
    duties[0] = 8'h40; exp_on[0] = 64;
    duties[1] = 8'h80; exp_on[1] = 128;
    duties[2] = 8'h00; exp_on[2] = 0;
    @(posedge clk); #1;
    apply_reset();
    led_in = 8'hFF;
    for (int d = 0; d < 3; d++) begin
      bus_write(2'd0, duties[d]);
      repeat (2) @(posedge clk);
      n_on = 0; n_off = 0; n_other = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        if (led_out === 8'hFF) n_on++;
        else if (led_out === 8'h00) n_off++;
        else n_other++;
      end
      checks++;
      if (n_on != exp_on[d] || n_off != 256 - exp_on[d] || n_other != 0) begin
        errors++;
        $display("FAIL pwm_duty_%h: on=%0d off=%0d other=%0d expected on=%0d off=%0d",
                 duties[d], n_on, n_off, n_other, exp_on[d], 256 - exp_on[d]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_blink();
    int bad_led, bad_st;
    logic ph, ph_prev;
    @(posedge clk); #1;
    apply_reset();
    led_in = 8'hFF;
    bus_write(2'd1, 8'h0F);
    bus_write(2'd2, 8'h02);
    bad_led = 0; bad_st = 0; ph_prev = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      bus_if.address = 2'd3;
      #1;
      ph = ((k / 48) % 2) == 0;
      if (bus_if.readdata !== {7'b0, ph}) bad_st++;
      if (k >= 2 && led_out !== (ph_prev ? 8'hFF : 8'hF0)) bad_led++;
      ph_prev = ph;
    end
    checks++;
    if (bad_st != 0) begin
      errors++;
      $display("FAIL blink_status: %0d cycles wrong for 48-cycle half period", bad_st);
    end
    checks++;
    if (bad_led != 0) begin
      errors++;
      $display("FAIL blink_led: %0d cycles differed from FF/F0 alternation", bad_led);
    end
  endtask

  task automatic test_period_restart();
    int bad_led, bad_st;
    logic ph, ph_prev;
    @(posedge clk); #1;
    apply_reset();
    led_in = 8'hFF;
    bus_write(2'd1, 8'h0F);
    bus_write(2'd2, 8'h02);
    repeat (47) @(posedge clk);
    #1;
    bus_if.address = 2'd3;
    #1;
    checks++;
    if (bus_if.readdata !== 8'h01) begin
      errors++;
      $display("FAIL restart_pre_phase: got %h expected 01", bus_if.readdata);
    end
    // This write lands on the edge where the 48-cycle toggle is due.
    bus_write(2'd2, 8'h01);
    bad_led = 0; bad_st = 0; ph_prev = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus_if.address = 2'd3;
      #1;
      ph = ((k / 32) % 2) == 0;
      if (k == 0) begin
        checks++;
        if (bus_if.readdata !== 8'h01) begin
          errors++;
          $display("FAIL restart_phase_at_write: got %h expected 01", bus_if.readdata);
        end
      end
      if (bus_if.readdata !== {7'b0, ph}) bad_st++;
      if (k >= 2 && led_out !== (ph_prev ? 8'hFF : 8'hF0)) bad_led++;
      ph_prev = ph;
    end
    checks++;
    if (bad_st != 0) begin
      errors++;
      $display("FAIL restart_status: %0d cycles wrong for 32-cycle half period", bad_st);
    end
    checks++;
    if (bad_led != 0) begin
      errors++;
      $display("FAIL restart_led: %0d cycles differed from expected pattern", bad_led);
    end
  endtask

  task automatic test_reset_mid_blink();
    logic found;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
    @(posedge clk); #1;
    apply_reset();
    led_in = 8'hFF;
    bus_write(2'd0, 8'h40);
    bus_write(2'd1, 8'h0F);
    bus_write(2'd2, 8'h0F);  // 256-cycle half period
    repeat (260) @(posedge clk);
    #1;
    bus_if.address = 2'd3;
    #1;
    checks++;
    if (bus_if.readdata !== 8'h00) begin
      errors++;
      $display("FAIL midreset_phase0: got %h expected 00", bus_if.readdata);
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (led_out === 8'hF0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_wait_led: led_out never reached F0 within 200 cycles, last %h", led_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (led_out !== 8'h00) begin
      errors++;
      $display("FAIL midreset_led_out: got %h expected 00", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      bus_if.address = 2'(a);
      #1;
      checks++;
      if (bus_if.readdata !== exp_rd[a]) begin
        errors++;
        $display("FAIL midreset_read_addr%0d: got %h expected %h", a, bus_if.readdata, exp_rd[a]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led_out !== 8'hFF) begin
      errors++;
      $display("FAIL midreset_after_release: got %h expected FF", led_out);
    end
  endtask

  task automatic test_reg_protect();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
    @(posedge clk); #1;
    apply_reset();
    bus_write(2'd3, 8'hFF);
    bus_if.address    = 2'd0;
    bus_if.writedata  = 8'h12;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_if.write_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_if.address = 2'(a);
      #1;
      checks++;
      if (bus_if.readdata !== exp_rd[a]) begin
        errors++;
        $display("FAIL protect_read_addr%0d: got %h expected %h", a, bus_if.readdata, exp_rd[a]);
      end
    end
    // Writes held during reset must be dropped.
    reset = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = 8'h11;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus_if.address = 2'd0;
    #1;
    checks++;
    if (bus_if.readdata !== 8'hFF) begin
      errors++;
      $display("FAIL protect_write_in_reset: DUTY got %h expected FF", bus_if.readdata);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    led_in = 8'h00;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 8'h00;
    test_reset();
    test_pwm();
    test_blink();
    test_period_restart();
    test_reset_mid_blink();
    test_reg_protect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
